// File: rtl/regfile_bypass_sb.sv
// Register file with write-to-read bypass, per-register busy scoreboard and a
// sequential zero-clear sweep that runs after reset or on request.

module regfile_bypass_sb_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            i_run,
  input  logic [AW-1:0]   i_rs,
  input  logic            i_wen,
  input  logic [AW-1:0]   i_rd,
  input  logic [XLEN-1:0] i_din,
  input  logic [XLEN-1:0] i_q,
  input  logic            i_busy,
  output logic [XLEN-1:0] o_dout,
  output logic            o_busy
);
  logic w_fwd;
  assign w_fwd = (BYPASS != 0) && i_wen && (i_rd == i_rs);

  // A completing write releases the waiting reader in the same cycle.
  always_comb begin
    o_dout = '0;
    o_busy = 1'b0;
    if (i_run && i_rs != '0) begin
      o_dout = w_fwd ? i_din : i_q;
      o_busy = i_busy & ~w_fwd;
    end
  end
endmodule

module regfile_bypass_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init_req,
  input  logic            wen,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] din,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] sdout1,
  output logic [XLEN-1:0] sdout2,
  input  logic            mark_en,
  input  logic [AW-1:0]   mark_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);
  localparam int NREG = 2**AW;
  localparam int NRP  = 2;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW:0]     r_init_idx, w_init_idx_nxt;
  logic [NREG-1:0] r_busy;
  logic [XLEN-1:0] r_rf [NREG];

  logic w_run, w_wr;
  assign w_run = (r_state == ST_RUN);
  assign w_wr  = w_run && wen && (rd != '0);
  assign ready = w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
    end
  end

  // init_idx carries an extra bit so the terminal compare never wraps.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    case (r_state)
      ST_INIT: begin
        w_init_idx_nxt = r_init_idx + (AW+1)'(1);
        if (r_init_idx == (AW+1)'(NREG-1)) begin
          w_state_nxt    = ST_RUN;
          w_init_idx_nxt = '0;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          w_state_nxt    = ST_INIT;
          w_init_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ST_INIT;
        w_init_idx_nxt = '0;
      end
    endcase
  end

  // Storage is cleared only by the sweep, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!w_run)    r_rf[r_init_idx[AW-1:0]] <= '0;
    else if (w_wr) r_rf[rd] <= din;
  end

  // Mark is applied after the clear so a new producer supersedes the completing one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (!w_run || init_req) begin
      r_busy <= '0;
    end else begin
      if (w_wr)                      r_busy[rd]      <= 1'b0;
      if (mark_en && mark_rd != '0)  r_busy[mark_rd] <= 1'b1;
    end
  end

  logic [NRP-1:0][AW-1:0]   w_rs;
  logic [NRP-1:0][XLEN-1:0] w_q;
  logic [NRP-1:0][XLEN-1:0] w_dout;
  logic [NRP-1:0]           w_busy;

  assign w_rs = {rs2, rs1};

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    assign w_q[p] = r_rf[w_rs[p]];
    regfile_bypass_sb_rdport #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp (
      .i_run  (w_run),
      .i_rs   (w_rs[p]),
      .i_wen  (wen),
      .i_rd   (rd),
      .i_din  (din),
      .i_q    (w_q[p]),
      .i_busy (r_busy[w_rs[p]]),
      .o_dout (w_dout[p]),
      .o_busy (w_busy[p])
    );
  end

  assign sdout1 = w_dout[0];
  assign sdout2 = w_dout[1];
  assign busy1  = w_busy[0];
  assign busy2  = w_busy[1];
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: driver queues expected outputs per cycle,
// a monitor pops and compares them on the falling edge.

module tb_regfile_bypass_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk, rst_n, init_req, wen, mark_en;
  logic [AW-1:0]   rd, rs1, rs2, mark_rd;
  logic [XLEN-1:0] din, sdout1, sdout2;
  logic            busy1, busy2, ready;

  regfile_bypass_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .wen(wen), .rd(rd), .din(din),
    .rs1(rs1), .rs2(rs2), .sdout1(sdout1), .sdout2(sdout2), .mark_en(mark_en),
    .mark_rd(mark_rd), .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  typedef struct {
    string           nm;
    logic [XLEN-1:0] d1, d2;
    logic            b1, b2, rdy;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() != 0) begin
        e = q.pop_front();
        chk({e.nm, ".sdout1"}, sdout1, e.d1);
        chk({e.nm, ".sdout2"}, sdout2, e.d2);
        chk({e.nm, ".busy1"}, {31'd0, busy1}, {31'd0, e.b1});
        chk({e.nm, ".busy2"}, {31'd0, busy2}, {31'd0, e.b2});
        chk({e.nm, ".ready"}, {31'd0, ready}, {31'd0, e.rdy});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic w, logic [AW-1:0] a, logic [XLEN-1:0] d,
                        logic [AW-1:0] r1, logic [AW-1:0] r2,
                        logic m, logic [AW-1:0] ma, logic ir);
    wen = w; rd = a; din = d; rs1 = r1; rs2 = r2;
    mark_en = m; mark_rd = ma; init_req = ir;
  endtask

  task automatic push_exp(string nm, logic [XLEN-1:0] d1, logic [XLEN-1:0] d2,
                          logic b1, logic b2, logic rdy);
    exp_t e;
    e.nm = nm; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.rdy = rdy;
    q.push_back(e);
  endtask

  // 32 cycles of ready=0 with zero outputs, then ready=1; junk drives ignored traffic.
  task automatic sweep_chk(string nm, bit junk);
    for (int i = 0; i < 32; i++) begin
      if (junk) set_in(1'b1, 5'd4, 32'hFFFF_FFFF, 5'd4, 5'd11, 1'b1, 5'd11, 1'b0);
      else      set_in(1'b0, '0, '0, AW'(i), AW'(31 - i), 1'b0, '0, 1'b0);
      push_exp($sformatf("%s_c%0d", nm, i), '0, '0, 1'b0, 1'b0, 1'b0);
      step();
    end
    set_in(1'b0, '0, '0, 5'd31, 5'd0, 1'b0, '0, 1'b0);
    push_exp({nm, "_rdy"}, '0, '0, 1'b0, 1'b0, 1'b1);
    step();
  endtask

  task automatic clear_chk(string nm);
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, '0, '0, AW'(i), AW'(i), 1'b0, '0, 1'b0);
      push_exp($sformatf("%s_x%0d", nm, i), '0, '0, 1'b0, 1'b0, 1'b1);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
    repeat (3) step();
    push_exp("in_reset", '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    sweep_chk("sweep0", 1'b0);
    clear_chk("clr0");

    // bypass then stored
    set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 1'b0, '0, 1'b0);
    push_exp("byp_x5", 32'hDEAD_BEEF, '0, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b0, '0, '0, 5'd5, 5'd5, 1'b0, '0, 1'b0);
    push_exp("stored_x5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1); step();

    // x0 write ignored
    set_in(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd5, 1'b0, '0, 1'b0);
    push_exp("x0_wr", '0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b0, '0, '0, 5'd0, 5'd0, 1'b0, '0, 1'b0);
    push_exp("x0_after", '0, '0, 1'b0, 1'b0, 1'b1); step();

    // scoreboard
    set_in(1'b0, '0, '0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0);
    push_exp("mark7", '0, '0, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b0, '0, '0, 5'd7, 5'd0, 1'b0, '0, 1'b0);
    push_exp("busy7", '0, '0, 1'b1, 1'b0, 1'b1); step();
    set_in(1'b1, 5'd6, 32'h66, 5'd7, 5'd6, 1'b0, '0, 1'b0);
    push_exp("wr6_busy7", '0, 32'h66, 1'b1, 1'b0, 1'b1); step();
    set_in(1'b1, 5'd7, 32'h77, 5'd7, 5'd7, 1'b0, '0, 1'b0);
    push_exp("wr7_release", 32'h77, 32'h77, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b0, '0, '0, 5'd7, 5'd6, 1'b0, '0, 1'b0);
    push_exp("x7_cleared", 32'h77, 32'h66, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b1, 5'd7, 32'h88, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0);
    push_exp("mark_wr7", 32'h88, '0, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b0, '0, '0, 5'd7, 5'd7, 1'b0, '0, 1'b0);
    push_exp("set_wins", 32'h88, 32'h88, 1'b1, 1'b1, 1'b1); step();
    set_in(1'b1, 5'd7, 32'h99, 5'd7, 5'd0, 1'b0, '0, 1'b0);
    push_exp("wr7_again", 32'h99, '0, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b0, '0, '0, 5'd7, 5'd0, 1'b0, '0, 1'b0);
    push_exp("x7_free", 32'h99, '0, 1'b0, 1'b0, 1'b1); step();

    // init_req re-clear with ignored traffic during the sweep
    set_in(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd0, 1'b0, '0, 1'b0);
    push_exp("wr3", 32'hA5A5_A5A5, '0, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b0, '0, '0, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0);
    push_exp("mark9", 32'hA5A5_A5A5, '0, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b1, 5'd5, 32'hCAFE_F00D, 5'd3, 5'd9, 1'b0, '0, 1'b1);
    push_exp("init_req", 32'hA5A5_A5A5, '0, 1'b0, 1'b1, 1'b1); step();
    sweep_chk("sweep1", 1'b1);
    clear_chk("clr1");

    // reset asserted at sweep index 10
    set_in(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
    push_exp("init_req2", '0, '0, 1'b0, 1'b0, 1'b1); step();
    set_in(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      push_exp($sformatf("pre_rst_c%0d", i), '0, '0, 1'b0, 1'b0, 1'b0);
      step();
    end
    rst_n = 1'b0;
    push_exp("mid_rst", '0, '0, 1'b0, 1'b0, 1'b0); step();
    rst_n = 1'b1;
    sweep_chk("sweep2", 1'b0);
    clear_chk("clr2");

    @(negedge clk);
    @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
